// File: rtl/floor_pkg.sv
// floor_pkg: shared slot states, difficulty tiers and LFSR constants for the floor scroller
package floor_pkg;
    typedef logic [0:0] slot_state_t;
    localparam slot_state_t ACTIVE = 1'b0;
    localparam slot_state_t HIDDEN = 1'b1;
    localparam int unsigned TIER_1 = 80;
    localparam int unsigned TIER_2 = 160;
    localparam int unsigned TIER_3 = 240;
    localparam int unsigned TIER_END = 320;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/floor_slot.sv
// floor_slot: one platform slot that scrolls, wraps off screen, hides, then respawns
module floor_slot
    import floor_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int RAND_W = 9,
    parameter int DIR = 0,
    parameter int Y_MIN = 40,
    parameter int Y_MAX = 460,
    parameter int X_MIN = 64,
    parameter int X_INIT = 150,
    parameter int Y_INIT = 160,
    parameter int HIDE_TICKS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic               tick,
    input  logic               pause,
    input  logic [RAND_W-1:0]  rand_x,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               en,
    output logic               wrap
);
    localparam logic [COORD_W-1:0] Y_LO = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] Y_HI = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0] Y_EXIT = DIR != 0 ? Y_LO : Y_HI;
    localparam logic [COORD_W-1:0] Y_ENTRY = DIR != 0 ? Y_HI : Y_LO;
    localparam logic [COORD_W-1:0] X_OFF = COORD_W'(X_MIN);
    localparam int HIDE_W = $clog2(HIDE_TICKS + 1);
    slot_state_t state;
    logic [HIDE_W-1:0] hide_cnt;
    logic [COORD_W-1:0] y_mv;
    // one step toward the exit; a slot already at or outside the bounds lands exactly on the exit
    always_comb
        y_mv = (y == Y_EXIT || y < Y_LO || y > Y_HI) ? Y_EXIT : DIR != 0 ? y - 1'b1 : y + 1'b1;
    // slot FSM: scroll while active, count ticks while hidden, respawn at the entry edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= ACTIVE;
            x <= COORD_W'(X_INIT);
            y <= COORD_W'(Y_INIT);
            en <= 1'b1;
            wrap <= 1'b0;
            hide_cnt <= '0;
        end else begin
            wrap <= 1'b0;
            if (state == ACTIVE && step) begin
                y <= y_mv;
                if (y_mv == Y_EXIT) begin
                    state <= HIDDEN;
                    en <= 1'b0;
                    hide_cnt <= HIDE_W'(HIDE_TICKS);
                    wrap <= 1'b1;
                end
            end else if (state == HIDDEN && tick && !pause) begin
                if (hide_cnt == HIDE_W'(1)) begin
                    state <= ACTIVE;
                    en <= 1'b1;
                    y <= Y_ENTRY;
                    x <= X_OFF + COORD_W'(rand_x);
                end else begin
                    hide_cnt <= hide_cnt - 1'b1;
                end
            end
        end
endmodule

// File: rtl/floor_scroller.sv
// floor_scroller: N-slot scrolling platform generator with pseudo-random respawn and passed-floor count
module floor_scroller
    import floor_pkg::*;
#(
    parameter int NUM_FLOORS = 4,
    parameter int COORD_W = 10,
    parameter int GAP_W = 9,
    parameter int CNT_W = 8,
    parameter int DIR = 0,
    parameter int Y_MIN = 40,
    parameter int Y_MAX = 460,
    parameter int X_BASE = 150,
    parameter int X_STEP = 150,
    parameter int Y_BASE = 160,
    parameter int Y_STEP = 100,
    parameter int X_MIN = 64,
    parameter int RAND_W = 9,
    parameter int HIDE_TICKS = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    input  logic                          scroll_en,
    input  logic                          pause,
    input  logic [GAP_W-1:0]              time_gap,
    output logic [NUM_FLOORS*COORD_W-1:0] floor_x,
    output logic [NUM_FLOORS*COORD_W-1:0] floor_y,
    output logic [NUM_FLOORS-1:0]         enable,
    output logic [NUM_FLOORS-1:0]         wrap_pulse,
    output logic [CNT_W-1:0]              passed_cnt
);
    localparam int SUM_W = CNT_W + $clog2(NUM_FLOORS + 1);
    logic [15:0] lfsr;
    logic tier_hit;
    logic step;
    logic [SUM_W-1:0] sum;
    // difficulty tiers: low gaps step every tick, higher tiers only on aligned gap values
    always_comb begin
        tier_hit = (time_gap == '0 || 32'(time_gap) >= TIER_END) ? 1'b0 :
                   32'(time_gap) < TIER_1 ? 1'b1 :
                   32'(time_gap) < TIER_2 ? ~time_gap[0] :
                   32'(time_gap) < TIER_3 ? ~|time_gap[1:0] : ~|time_gap[2:0];
        step = tick & scroll_en & ~pause & tier_hit;
    end
    // running total plus the slots that wrapped this cycle, wide enough to detect overflow
    always_comb begin
        sum = SUM_W'(passed_cnt);
        for (int k = 0; k < NUM_FLOORS; k++) sum = sum + SUM_W'(wrap_pulse[k]);
    end
    // LFSR free-runs every clock, so respawn x keeps varying even while paused
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr <= LFSR_SEED;
        else lfsr <= lfsr_next(lfsr);
    // passed-floor counter saturates at all-ones
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) passed_cnt <= '0;
        else passed_cnt <= sum > SUM_W'({CNT_W{1'b1}}) ? '1 : sum[CNT_W-1:0];
    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_slot
        floor_slot #(
            .COORD_W(COORD_W), .RAND_W(RAND_W), .DIR(DIR), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
            .X_MIN(X_MIN), .X_INIT(X_BASE + i * X_STEP), .Y_INIT(Y_BASE + i * Y_STEP),
            .HIDE_TICKS(HIDE_TICKS)
        ) u_slot (
            .clk(clk),
            .rst_n(rst_n),
            .step(step),
            .tick(tick),
            .pause(pause),
            .rand_x(RAND_W'({lfsr, lfsr} >> (16 - i))),
            .x(floor_x[i*COORD_W +: COORD_W]),
            .y(floor_y[i*COORD_W +: COORD_W]),
            .en(enable[i]),
            .wrap(wrap_pulse[i])
        );
    end
endmodule
